nn_sigmoid_arbiter: RTL

Time-shares one multi-cycle sigmoid_approx unit between NUM_REQ requesters, for example hidden neurons h1/h2 and the output neuron.
- Accepts one operand at a time from the requesters, using round-robin arbitration.
- Issues a one-cycle in_valid pulse to the sigmoid unit.
- Waits for its out_valid, with a watchdog timeout.
- Returns the result to the granted requester.
Sits between the layer adders and a single shared sigmoid instance in the NN top, replacing the per-neuron sigmoid copies.

---
 rtl/nn_ctrl_pkg.sv | 21 ++
 rtl/nn_sigmoid_arbiter_rr_arbiter.sv | 37 +++
 rtl/nn_sigmoid_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the NN control path.
// Holds the sigmoid arbiter state encoding and float helpers.
package nn_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   localparam int DEF_TIMEOUT_CYCLES = 255;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_HALF = 32'h3F00_0000;

   function automatic int float_w(input int e_w, input int m_w);
      return e_w + m_w;
   endfunction

endpackage

// File: rtl/nn_sigmoid_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Scans from last_grant+1 modulo NUM_REQ for the first request.
module rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               any
);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Walk farthest-first so the nearest requester wins the last write.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = |req;
      sum       = '0;
      idx       = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sum = {1'b0, last_grant} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ))
            sum = sum - (IW+1)'(NUM_REQ);
         idx = sum[IW-1:0];
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/nn_sigmoid_arbiter.sv
// Time-shares one multi-cycle sigmoid unit between NUM_REQ requesters.
// Round-robin accept, one-cycle issue pulse, watchdog wait, one-cycle response.
module nn_sigmoid_arbiter
   import nn_ctrl_pkg::*;
#(
   parameter  int exp_width      = 8,
   parameter  int mant_width     = 24,
   parameter  int NUM_REQ        = 3,
   parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int W              = float_w(exp_width, mant_width),
   localparam int IW             = $clog2(NUM_REQ),
   localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           round_mode,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*W-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [W-1:0]         rsp_data,
   output logic                 rsp_timeout,
   output logic                 busy,
   output logic [W-1:0]         sig_in_x,
   output logic                 sig_in_valid,
   output logic [2:0]           sig_round_mode,
   input  logic [W-1:0]         sig_out,
   input  logic                 sig_out_valid
);

   arb_state_t state, state_nxt;

   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      g_reg;
   logic [W-1:0]       op_reg;
   logic [W-1:0]       res_reg;
   logic               to_reg;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_any;
   logic [W-1:0]       req_arr [NUM_REQ];
   logic               expired;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         req_arr[i] = req_data[i*W +: W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (gnt),
      .grant_idx  (gnt_idx),
      .any        (gnt_any)
   );

   assign expired        = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign sig_in_x       = op_reg;
   assign sig_round_mode = round_mode;

   always_comb begin
      state_nxt    = state;
      req_ready    = '0;
      sig_in_valid = 1'b0;
      rsp_valid    = '0;
      rsp_data     = '0;
      rsp_timeout  = 1'b0;
      busy         = (state != IDLE);
      unique case (state)
         IDLE: begin
            // Gated so reset silences the grant path too.
            req_ready = rst ? '0 : gnt;
            if (gnt_any)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            sig_in_valid = 1'b1;
            state_nxt    = WAIT;
         end
         WAIT: begin
            if (sig_out_valid || expired)
               state_nxt = RESP;
         end
         RESP: begin
            rsp_valid   = NUM_REQ'(1) << g_reg;
            rsp_data    = res_reg;
            rsp_timeout = to_reg;
            state_nxt   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= IW'(NUM_REQ - 1);
         g_reg      <= '0;
         op_reg     <= '0;
         res_reg    <= '0;
         to_reg     <= 1'b0;
         cnt        <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (gnt_any) begin
                  op_reg <= req_arr[gnt_idx];
                  g_reg  <= gnt_idx;
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               // A result on the last count still beats the watchdog.
               if (sig_out_valid) begin
                  res_reg <= sig_out;
                  to_reg  <= 1'b0;
               end else if (expired) begin
                  res_reg <= '0;
                  to_reg  <= 1'b1;
               end
            end
            RESP: last_grant <= g_reg;
         endcase
      end
   end

endmodule
